decode_issue: RTL
=================

Name: decode_issue

Overview:
- Decode/issue stage sitting directly upstream of regfile.
- Accepts fetched RV32I instructions over a valid/ready handshake, decodes fields and immediates, drives the regfile read addresses, and registers the operands into an execute-facing pipeline register.
- Maintains a 32-entry scoreboard of pending destination writes; stalls on RAW hazards and forwards same-cycle writeback data.

Parameters:
- DATA_WIDTH, 32, datapath and register width.
- REG_BUS_WIDTH, $clog2(DATA_WIDTH), register address width; 5 at default.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  reset; asynchronous, active-low.
- if_valid  in  1  fetch has an instruction.
- if_ready  out  1  stage accepts the instruction this cycle.
- if_instr  in  32  instruction word.
- if_pc  in  DATA_WIDTH  PC of the instruction.
- rs1  out  REG_BUS_WIDTH  regfile read address 1; combinational from if_instr[19:15].
- rs2  out  REG_BUS_WIDTH  regfile read address 2; combinational from if_instr[24:20].
- rs1_data  in  DATA_WIDTH  regfile read data 1; combinational, same cycle.
- rs2_data  in  DATA_WIDTH  regfile read data 2.
- wb_valid  in  1  writeback retires a write this cycle.
- wb_rd  in  REG_BUS_WIDTH  retiring destination register.
- wb_data  in  DATA_WIDTH  retiring data; the regfile commits it at this same posedge.
- flush  in  1  kill the contents of the output register.
- ex_valid  out  1  output register holds an instruction.
- ex_ready  in  1  execute consumes it.
- ex_pc, ex_rs1_val, ex_rs2_val, ex_imm  out  DATA_WIDTH each  registered PC, operands, sign-extended immediate.
- ex_rd  out  REG_BUS_WIDTH  destination register.
- ex_rd_write  out  1  instruction writes rd.
- ex_opcode  out  7  opcode.
- ex_funct3  out  3  funct3.
- ex_funct7  out  7  funct7.
- ex_illegal  out  1  unrecognised opcode.

Behaviour:
- Reset: all ex_* outputs are 0, the scoreboard is cleared, and if_ready=0 while rst_n is low.
- Operand use by opcode:
  - R 0110011, STORE 0100011, BRANCH 1100011: rs1 and rs2.
  - OP-IMM 0010011, LOAD 0000011, JALR 1100111: rs1 only.
  - LUI, AUIPC, JAL: no source operands.
- rd_write is set for R, OP-IMM, LOAD, JALR, JAL, LUI, AUIPC, forced to 0 when rd==0.
- Any other opcode: ex_illegal=1, rd_write=0, no scoreboard set.
- Immediates: I, S, B, U, J formats; sign-extended to DATA_WIDTH; 0 for R-type.
- Hazard: a used source rs!=0 whose scoreboard bit is set, unless it is forwardable (see Optional Feature).
- Handshake: if_ready = !ex_valid || ex_ready, gated low by a hazard or by flush.
- Transfer occurs on if_valid && if_ready.
- Latency: an instruction accepted at posedge N has ex_valid=1 immediately after N.
- When ex_valid && !ex_ready, all ex_* outputs hold stable.
- Operand capture: ex_rsX_val = forwarded wb_data if forwarding applies; else rsX_data; 0 when rs==0.
- Scoreboard set: on transfer with rd_write, bit[rd] is set.
- Scoreboard clear: on wb_valid, bit[wb_rd] is cleared.
- Same-cycle set and clear of the same rd: set wins.
- Bit 0 is never set.
- Flush: at the next posedge, ex_valid=0 and the held instruction's scoreboard bit is cleared if its rd_write=1. No instruction is accepted in the flush cycle.
- Reset mid-operation: immediate clear of all state, with no handshake completion.

Optional Feature:
- Macro DECODE_WB_FWD_EN.
- Defined: a source whose bit is set but matches wb_rd with wb_valid is not a hazard; the operand takes wb_data. This gives zero-bubble issue behind writeback.
- Undefined: no forwarding. Issue waits until the scoreboard bit is clear, i.e. one cycle after the writeback posedge, so the regfile read returns the committed value.

Decomposition:
- Package decode_pkg holds:
  - opcode localparams.
  - imm_fmt_e enum (I, S, B, U, J, NONE).
  - decoded_instr_t struct (rd, rd_write, funct3, funct7, opcode, imm, use_rs1, use_rs2, illegal).
- Sub-module instr_decoder: purely combinational, if_instr -> decoded_instr_t.
- The scoreboard, handshake and output register stay in decode_issue.

Test Plan:
- Reset -> all ex_* = 0, if_ready=0 during reset; if_ready=1 one cycle after release with ex_valid=0.
- Issue ADDI x5,x0,-3 (0xFFD00293) with ex_ready=1 -> next cycle ex_imm=0xFFFFFFFD, ex_rd=5, ex_rd_write=1; scoreboard bit 5 set.
- Back-to-back ADD x6,x5,x5 while bit 5 set and no writeback -> if_ready=0. Drive wb_valid, wb_rd=5, wb_data=0x1234:
  - with DECODE_WB_FWD_EN: accepted that cycle, ex_rs1_val=ex_rs2_val=0x1234.
  - without: accepted one cycle later.
- Hold ex_ready=0 for 3 cycles with a valid SW -> ex_* stable, if_ready=0; release -> the next instruction is accepted that cycle.
- Assert flush while LW x7 is held -> ex_valid=0 next cycle; an instruction reading x7 then issues without stall.
- Opcode 0x7F -> ex_illegal=1, ex_rd_write=0, scoreboard unchanged. ADDI x0 -> ex_rd_write=0, bit 0 stays clear.

Source files
------------

// File: rtl/decode_pkg.sv
// Decode package: RV32I opcode constants, immediate-format enum, the decoded
// instruction record shared by instr_decoder and decode_issue, and the
// immediate builder.
// Ports: none (package).
package decode_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J,
        IMM_NONE
    } imm_fmt_e;

    typedef struct packed {
        logic [4:0]  rd;
        logic        rd_write;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [6:0]  opcode;
        logic [31:0] imm;
        logic        use_rs1;
        logic        use_rs2;
        logic        illegal;
    } decoded_instr_t;

    // Assemble the 32-bit sign-extended immediate for the given format.
    function automatic logic [31:0] gen_imm(input logic [31:0] instr, input imm_fmt_e fmt);
        logic [31:0] imm;
        case (fmt)
            IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm = {instr[31:12], 12'b0};
            IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = '0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/decode_issue_instr_decoder.sv
// instr_decoder: purely combinational RV32I field/immediate decoder.
// Ports:
//   instr_i  in   32-bit instruction word
//   dec_o    out  decoded_instr_t (fields, immediate, operand use, illegal)
module instr_decoder
    import decode_pkg::*;
(
    input  logic [31:0]    instr_i,
    output decoded_instr_t dec_o
);

    imm_fmt_e fmt;
    logic     writes_rd;

    always_comb begin
        fmt           = IMM_NONE;
        writes_rd     = 1'b0;
        dec_o         = '0;
        dec_o.opcode  = instr_i[6:0];
        dec_o.rd      = instr_i[11:7];
        dec_o.funct3  = instr_i[14:12];
        dec_o.funct7  = instr_i[31:25];

        case (instr_i[6:0])
            OPC_OP: begin
                dec_o.use_rs1 = 1'b1;
                dec_o.use_rs2 = 1'b1;
                writes_rd     = 1'b1;
            end
            OPC_STORE: begin
                fmt           = IMM_S;
                dec_o.use_rs1 = 1'b1;
                dec_o.use_rs2 = 1'b1;
            end
            OPC_BRANCH: begin
                fmt           = IMM_B;
                dec_o.use_rs1 = 1'b1;
                dec_o.use_rs2 = 1'b1;
            end
            OPC_OP_IMM, OPC_LOAD, OPC_JALR: begin
                fmt           = IMM_I;
                dec_o.use_rs1 = 1'b1;
                writes_rd     = 1'b1;
            end
            OPC_LUI, OPC_AUIPC: begin
                fmt       = IMM_U;
                writes_rd = 1'b1;
            end
            OPC_JAL: begin
                fmt       = IMM_J;
                writes_rd = 1'b1;
            end
            default: dec_o.illegal = 1'b1;
        endcase

        // x0 is hardwired; never claim it as a pending destination.
        dec_o.rd_write = writes_rd && (instr_i[11:7] != 5'd0);
        dec_o.imm      = gen_imm(instr_i, fmt);
    end

endmodule

// File: rtl/decode_issue.sv
// decode_issue: RV32I decode/issue stage in front of the register file.
// Accepts instructions on a valid/ready handshake, drives regfile read
// addresses, tracks pending destination writes in a 32-bit scoreboard,
// stalls on RAW hazards and registers operands for execute.
// Build option: define DECODE_WB_FWD_EN to forward same-cycle writeback data
// (zero-bubble issue behind a retiring write); otherwise issue waits until the
// scoreboard bit has cleared and the regfile holds the committed value.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   if_valid/if_ready           fetch handshake; if_instr, if_pc payload
//   rs1, rs2                    regfile read addresses (combinational)
//   rs1_data, rs2_data          regfile read data (same cycle)
//   wb_valid, wb_rd, wb_data    retiring write
//   flush                       drop the output register contents
//   ex_valid/ex_ready           execute handshake
//   ex_pc, ex_rs1_val, ex_rs2_val, ex_imm, ex_rd, ex_rd_write,
//   ex_opcode, ex_funct3, ex_funct7, ex_illegal   registered decode results
module decode_issue
    import decode_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int REG_BUS_WIDTH = $clog2(DATA_WIDTH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     if_valid,
    output logic                     if_ready,
    input  logic [31:0]              if_instr,
    input  logic [DATA_WIDTH-1:0]    if_pc,
    output logic [REG_BUS_WIDTH-1:0] rs1,
    output logic [REG_BUS_WIDTH-1:0] rs2,
    input  logic [DATA_WIDTH-1:0]    rs1_data,
    input  logic [DATA_WIDTH-1:0]    rs2_data,
    input  logic                     wb_valid,
    input  logic [REG_BUS_WIDTH-1:0] wb_rd,
    input  logic [DATA_WIDTH-1:0]    wb_data,
    input  logic                     flush,
    output logic                     ex_valid,
    input  logic                     ex_ready,
    output logic [DATA_WIDTH-1:0]    ex_pc,
    output logic [DATA_WIDTH-1:0]    ex_rs1_val,
    output logic [DATA_WIDTH-1:0]    ex_rs2_val,
    output logic [DATA_WIDTH-1:0]    ex_imm,
    output logic [REG_BUS_WIDTH-1:0] ex_rd,
    output logic                     ex_rd_write,
    output logic [6:0]               ex_opcode,
    output logic [2:0]               ex_funct3,
    output logic [6:0]               ex_funct7,
    output logic                     ex_illegal
);

    decoded_instr_t dec;

    instr_decoder u_instr_decoder (
        .instr_i (if_instr),
        .dec_o   (dec)
    );

    assign rs1 = REG_BUS_WIDTH'(if_instr[19:15]);
    assign rs2 = REG_BUS_WIDTH'(if_instr[24:20]);

    logic                     ex_valid_q,    ex_valid_d;
    logic [DATA_WIDTH-1:0]    ex_pc_q,       ex_pc_d;
    logic [DATA_WIDTH-1:0]    ex_rs1_val_q,  ex_rs1_val_d;
    logic [DATA_WIDTH-1:0]    ex_rs2_val_q,  ex_rs2_val_d;
    logic [DATA_WIDTH-1:0]    ex_imm_q,      ex_imm_d;
    logic [REG_BUS_WIDTH-1:0] ex_rd_q,       ex_rd_d;
    logic                     ex_rd_write_q, ex_rd_write_d;
    logic [6:0]               ex_opcode_q,   ex_opcode_d;
    logic [2:0]               ex_funct3_q,   ex_funct3_d;
    logic [6:0]               ex_funct7_q,   ex_funct7_d;
    logic                     ex_illegal_q,  ex_illegal_d;
    logic [31:0]              sb_q,          sb_d;

    logic fwd1, fwd2, hazard, ready, xfer;

    always_comb begin
        fwd1 = 1'b0;
        fwd2 = 1'b0;
`ifdef DECODE_WB_FWD_EN
        fwd1 = wb_valid && (wb_rd == rs1) && (rs1 != '0);
        fwd2 = wb_valid && (wb_rd == rs2) && (rs2 != '0);
`endif
        hazard = (dec.use_rs1 && (rs1 != '0) && sb_q[rs1] && !fwd1) ||
                 (dec.use_rs2 && (rs2 != '0) && sb_q[rs2] && !fwd2);
        // rst_n gates ready so nothing is offered as accepted during reset.
        ready  = rst_n && (!ex_valid_q || ex_ready) && !hazard && !flush;
        xfer   = if_valid && ready;

        ex_valid_d    = ex_valid_q;
        ex_pc_d       = ex_pc_q;
        ex_rs1_val_d  = ex_rs1_val_q;
        ex_rs2_val_d  = ex_rs2_val_q;
        ex_imm_d      = ex_imm_q;
        ex_rd_d       = ex_rd_q;
        ex_rd_write_d = ex_rd_write_q;
        ex_opcode_d   = ex_opcode_q;
        ex_funct3_d   = ex_funct3_q;
        ex_funct7_d   = ex_funct7_q;
        ex_illegal_d  = ex_illegal_q;

        // Clears first, then the set, so a same-cycle set of the same rd wins.
        sb_d = sb_q;
        if (wb_valid) begin
            sb_d[wb_rd] = 1'b0;
        end
        if (flush && ex_valid_q && ex_rd_write_q) begin
            sb_d[ex_rd_q] = 1'b0;
        end
        if (xfer && dec.rd_write) begin
            sb_d[dec.rd] = 1'b1;
        end
        sb_d[0] = 1'b0;

        if (flush) begin
            ex_valid_d = 1'b0;
        end else if (xfer) begin
            ex_valid_d    = 1'b1;
            ex_pc_d       = if_pc;
            ex_rs1_val_d  = (rs1 == '0) ? '0 : (fwd1 ? wb_data : rs1_data);
            ex_rs2_val_d  = (rs2 == '0) ? '0 : (fwd2 ? wb_data : rs2_data);
            ex_imm_d      = DATA_WIDTH'($signed(dec.imm));
            ex_rd_d       = REG_BUS_WIDTH'(dec.rd);
            ex_rd_write_d = dec.rd_write;
            ex_opcode_d   = dec.opcode;
            ex_funct3_d   = dec.funct3;
            ex_funct7_d   = dec.funct7;
            ex_illegal_d  = dec.illegal;
        end else if (ex_ready) begin
            ex_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q    <= 1'b0;
            ex_pc_q       <= '0;
            ex_rs1_val_q  <= '0;
            ex_rs2_val_q  <= '0;
            ex_imm_q      <= '0;
            ex_rd_q       <= '0;
            ex_rd_write_q <= 1'b0;
            ex_opcode_q   <= '0;
            ex_funct3_q   <= '0;
            ex_funct7_q   <= '0;
            ex_illegal_q  <= 1'b0;
            sb_q          <= '0;
        end else begin
            ex_valid_q    <= ex_valid_d;
            ex_pc_q       <= ex_pc_d;
            ex_rs1_val_q  <= ex_rs1_val_d;
            ex_rs2_val_q  <= ex_rs2_val_d;
            ex_imm_q      <= ex_imm_d;
            ex_rd_q       <= ex_rd_d;
            ex_rd_write_q <= ex_rd_write_d;
            ex_opcode_q   <= ex_opcode_d;
            ex_funct3_q   <= ex_funct3_d;
            ex_funct7_q   <= ex_funct7_d;
            ex_illegal_q  <= ex_illegal_d;
            sb_q          <= sb_d;
        end
    end

    assign if_ready    = ready;
    assign ex_valid    = ex_valid_q;
    assign ex_pc       = ex_pc_q;
    assign ex_rs1_val  = ex_rs1_val_q;
    assign ex_rs2_val  = ex_rs2_val_q;
    assign ex_imm      = ex_imm_q;
    assign ex_rd       = ex_rd_q;
    assign ex_rd_write = ex_rd_write_q;
    assign ex_opcode   = ex_opcode_q;
    assign ex_funct3   = ex_funct3_q;
    assign ex_funct7   = ex_funct7_q;
    assign ex_illegal  = ex_illegal_q;

endmodule
